// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and slave FSM state type.
// Used by ahb_sram_slave, ahb_burst_addr_calc and the matching ahb_master.
//   htrans_e    - HTRANS transfer type codes
//   hburst_e    - HBURST burst type codes
//   hsize_e     - HSIZE transfer size codes (byte/halfword/word)
//   hresp_e     - HRESP response codes
//   slv_state_e - data-phase state of the SRAM slave
//   wrap_beats  - beat count of a wrapping burst, 0 for non-wrapping bursts
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slv_state_e;

    function automatic logic [4:0] wrap_beats(input logic [2:0] burst);
        return burst == HBURST_WRAP4  ? 5'd4  :
               burst == HBURST_WRAP8  ? 5'd8  :
               burst == HBURST_WRAP16 ? 5'd16 : 5'd0;
    endfunction

endpackage

// File: rtl/ahb_burst_addr_calc.sv
// ahb_burst_addr_calc: combinational next-beat address for AHB bursts.
//   addr_i      - current beat byte address
//   size_i      - HSIZE of the burst
//   burst_i     - HBURST of the burst
//   next_addr_o - address the following SEQ beat must carry
// Incrementing bursts (and SINGLE) step by the transfer size; wrapping bursts
// keep the bits above the wrap boundary and roll the low bits around.
module ahb_burst_addr_calc
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [2:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    logic [4:0]        beats;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        beats       = wrap_beats(burst_i);
        incr        = addr_i + (ADDR_W'(1) << size_i);
        // mask covers the log2(beats << size) bits that wrap
        mask        = (ADDR_W'(beats) << size_i) - ADDR_W'(1);
        next_addr_o = beats != 5'd0 ? (addr_i & ~mask) | (incr & mask) : incr;
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word-addressed SRAM slave with programmable waits.
//   HCLK, HRESET   - bus clock, asynchronous active-low reset
//   HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS - address phase inputs
//   HWDATA         - write data, sampled on the edge that ends DATA
//   HREADY, HRESP  - bus ready and response (sole slave, drives bus HREADY)
//   HRDATA         - read data, non-zero only in a read DATA cycle
//   burst_err      - one-cycle pulse when a SEQ beat misses its expected address
// Out-of-range, illegal-size and misaligned accesses get a two-cycle ERROR.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HWDATA,
    output logic              HREADY,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              burst_err
);

    localparam int                IDX_W = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_DEPTH * 4);

    slv_state_e        state_q;
    logic              hready_q;
    logic              hresp_q;
    logic              burst_err_q;
    logic [2:0]        cnt_q;
    logic [IDX_W+1:0]  addr_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] exp_q;
    logic              exp_vld_q;
    logic [31:0]       mem_q [MEM_DEPTH];

    logic              accept_d;
    logic              seq_d;
    logic              err_d;
    logic [ADDR_W-1:0] exp_d;
    logic [3:0]        be_d;
    logic [IDX_W-1:0]  idx_d;

    ahb_burst_addr_calc #(.ADDR_W(ADDR_W)) u_calc (
        .addr_i      (HADDR),
        .size_i      (HSIZE),
        .burst_i     (HBURST),
        .next_addr_o (exp_d)
    );

    always_comb begin
        accept_d = hready_q && HSEL && HTRANS[1];
        seq_d    = HTRANS == HTRANS_SEQ;
        err_d    = HADDR >= LIMIT || HSIZE > HSIZE_WORD ||
                   (HSIZE == HSIZE_HALF && HADDR[0]) ||
                   (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'd0);
        idx_d    = addr_q[IDX_W+1:2];
        // little-endian lane select; size_q only holds legal sizes
        be_d     = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                   size_q == 2'd1 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= S_IDLE;
            hready_q    <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            burst_err_q <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            size_q      <= '0;
            exp_q       <= '0;
            exp_vld_q   <= 1'b0;
        end else begin
            // expected address is only meaningful after a non-SINGLE beat
            burst_err_q <= accept_d && seq_d && exp_vld_q && HADDR != exp_q;
            if (accept_d) begin
                addr_q    <= HADDR[IDX_W+1:0];
                wr_q      <= HWRITE;
                size_q    <= HSIZE[1:0];
                exp_q     <= exp_d;
                exp_vld_q <= HBURST != HBURST_SINGLE;
                if (err_d) begin
                    state_q  <= S_ERR1;
                    hready_q <= 1'b0;
                    hresp_q  <= HRESP_ERROR;
                end else if (WAIT_STATES > 0) begin
                    state_q  <= S_WAIT;
                    hready_q <= 1'b0;
                    hresp_q  <= HRESP_OKAY;
                    cnt_q    <= 3'(WAIT_STATES - 1);
                end else begin
                    state_q  <= S_DATA;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            end else begin
                case (state_q)
                    S_WAIT: begin
                        if (cnt_q == 3'd0) begin
                            state_q  <= S_DATA;
                            hready_q <= 1'b1;
                        end
                        cnt_q <= cnt_q - 3'd1;
                    end
                    S_ERR1: begin
                        state_q  <= S_ERR2;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_ERROR;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                endcase
            end
        end
    end

    // a reset forces state_q to IDLE immediately, so an aborted transfer never writes
    always_ff @(posedge HCLK) begin
        if (state_q == S_DATA && wr_q)
            for (int b = 0; b < 4; b++)
                if (be_d[b]) mem_q[idx_d][b*8 +: 8] <= HWDATA[b*8 +: 8];
    end

    assign HREADY    = hready_q;
    assign HRESP     = hresp_q;
    assign burst_err = burst_err_q;
    assign HRDATA    = (state_q == S_DATA && !wr_q) ? mem_q[idx_d] : 32'h0;

endmodule
